sm_fv_bank_loader: RTL and testbench
====================================

Name: sm_fv_bank_loader

Overview:
Downstream consumer of the big-FV bank controller's iteration stream (sos/eos/FV_data/A), registered one cycle after the big bank's SRAM read.
Writes each beat into a local single-port small-FV SRAM split into two ping-pong halves. The Vertex/Edge compute side reads one full half while the next iteration's stream fills the other.
Owns half-status tracking, read/write port arbitration, and overflow and range error flagging.

Parameters:
FV_BW, 64, width of one FV line (matches FV_bandwidth)
ADDR_W, 7, line address width within one half
DEPTH, 128, lines per half (must be <= 2**ADDR_W)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_sos  in  1  start of stream; this cycle carries beat 0
in_eos  in  1  end of stream; this cycle carries the last beat
in_data  in  FV_BW  stream line data
in_addr  in  ADDR_W  line address within half (the A field)
sram_cen  out  1  SRAM chip enable, active low
sram_wen  out  1  SRAM write enable, active low
sram_addr  out  ADDR_W+1  {half_sel, line}
sram_d  out  FV_BW  SRAM write data
sram_q  in  FV_BW  SRAM read data, valid 1 cycle after read CEN
rd_req  in  1  consumer read request
rd_addr  in  ADDR_W  consumer line address in the readable half
rd_ready  out  1  read accepted this cycle (combinational)
rd_valid  out  1  rd_data valid
rd_data  out  FV_BW  read data
release_half  in  1  consumer has finished with the readable half
half_ready  out  1  readable half is full
half_lines  out  ADDR_W+1  beats written into the readable half
loaded_pulse  out  1  one-cycle pulse when a half completes
err_overflow  out  1  sticky: sos arrived while the fill half was still full
err_range  out  1  sticky: beat address >= DEPTH

Behaviour:
- Interface: reset is asynchronous, active-low; clock is clk.
- Reset: fill_sel=0, rd_sel=0, full=2'b00, in_stream=0, both line counters 0. All outputs 0 except sram_cen=1 and sram_wen=1.
- Stream FSM, states IDLE and STREAM:
  - IDLE, in_sos with full[fill_sel]=0: go to STREAM, clear lines[fill_sel], write the beat.
  - IDLE, in_sos with full[fill_sel]=1: set err_overflow, enter DROP until eos. No writes, no status change.
  - STREAM, each cycle is a beat: write in_data to {fill_sel, in_addr}, increment lines[fill_sel].
  - STREAM, in_eos: write the last beat, set full[fill_sel]=1, toggle fill_sel, pulse loaded_pulse next cycle, return to IDLE.
  - in_sos && in_eos in the same cycle: single-beat stream.
  - in_sos while in STREAM: restart. Clear the counter and keep fill_sel.
  - in_eos in IDLE without sos: ignored.
- Range check: a beat with in_addr >= DEPTH is not written and sets err_range. It is still counted toward eos detection but not toward lines.
- Arbitration: a stream write always wins the SRAM port.
  - rd_ready = half_ready && !(write this cycle).
  - An accepted read drives cen=0, wen=1, addr={rd_sel, rd_addr}.
  - rd_valid and rd_data (=sram_q) follow exactly 1 cycle after acceptance.
  - An unaccepted rd_req must be held by the consumer.
- Readable half:
  - half_ready = full[rd_sel]; half_lines = lines[rd_sel].
  - release_half with half_ready: full[rd_sel]<=0, toggle rd_sel.
  - release_half without half_ready: ignored.
  - release_half and eos in the same cycle: both apply. The eos targets fill_sel, which never equals rd_sel while the rd_sel half is full.
- Line counters saturate at DEPTH.
- Reset mid-stream: everything returns to reset values immediately. Any in-flight rd_valid is lost.

Optional Feature:
SMFV_ERRCNT_EN:
- Defined: adds output err_cnt [7:0]. It counts dropped beats (overflow plus range), saturating at 255, and clears only on reset.
- Undefined: port and logic absent. The sticky flags are unchanged.

Decomposition:
- Shared package sm_fv_pkg: stream packet typedef {sos, eos, FV_data, A} matching the big-bank output, state enum {IDLE, STREAM, DROP}, and DEPTH/ADDR_W constants.
- One natural sub-module: sm_fv_half_status. It holds full[1:0], fill_sel, rd_sel and the lines counters, with mark_full/release inputs.

Test Plan:
- Stream sos at A=0 through eos at A=63, then release_half -> 64 SRAM writes to {0, 0..63}, loaded_pulse one cycle after eos, half_ready=1, half_lines=64. After release, half_ready=0 and rd_sel=1.
- Read addr 5 with no stream active -> rd_ready=1, rd_valid one cycle later with rd_data = the data written at line 5.
- Read held during a 4-beat stream into half 1 -> rd_ready=0 for those 4 cycles, then the read is accepted. No write is lost.
- Two streams complete without release, then a third sos -> err_overflow=1, no SRAM writes, full stays 2'b11.
- Beat with in_addr=DEPTH -> no write, err_range=1, lines excludes that beat. With SMFV_ERRCNT_EN defined, err_cnt=1.
- Reset asserted mid-stream at beat 10 -> all outputs reset immediately. A new sos then fills half 0 from line 0.

Source files
------------

// File: rtl/sm_fv_pkg.sv
// Shared types and default geometry for the small-FV bank loader.
// Stream packet layout mirrors the big-bank controller's output record.
package sm_fv_pkg;

    localparam int FV_BW_C  = 64;
    localparam int ADDR_W_C = 7;
    localparam int DEPTH_C  = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                sos;
        logic                eos;
        logic [FV_BW_C-1:0]  fv_data;
        logic [ADDR_W_C-1:0] a;
    } stream_pkt_t;

endpackage

// File: rtl/sm_fv_bank_loader_if.sv
// Consumer-side port of the small-FV loader: line reads and half hand-back.
// The master is the Vertex/Edge compute side; the slave is the loader.
interface sm_fv_bank_loader_if
    import sm_fv_pkg::*;
#(
    parameter int FV_BW  = FV_BW_C,
    parameter int ADDR_W = ADDR_W_C
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [FV_BW-1:0]  rd_data;
    logic              release_half;
    logic              half_ready;
    logic [ADDR_W:0]   half_lines;

    modport master (
        output rd_req, rd_addr, release_half,
        input  rd_ready, rd_valid, rd_data, half_ready, half_lines
    );

    modport slave (
        input  rd_req, rd_addr, release_half,
        output rd_ready, rd_valid, rd_data, half_ready, half_lines
    );
endinterface

// File: rtl/sm_fv_half_status.sv
// Ping-pong half bookkeeping: full flags, fill/read selectors, per-half line counts.
// Release and mark_full may land together; they always address different halves.
module sm_fv_half_status
    import sm_fv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_C,
    parameter int DEPTH  = DEPTH_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_lines_i,
    input  logic            inc_line_i,
    input  logic            mark_full_i,
    input  logic            release_i,
    output logic            fill_sel_o,
    output logic            rd_sel_o,
    output logic            fill_full_o,
    output logic            half_ready_o,
    output logic [ADDR_W:0] half_lines_o
);
    localparam logic [ADDR_W:0] LINES_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LINE_ONE  = (ADDR_W+1)'(1);

    logic [1:0]      full_q, full_d;
    logic            fill_sel_q, fill_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [ADDR_W:0] lines_q [2];
    logic [ADDR_W:0] lines_d [2];

    always_comb begin
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        rd_sel_d   = rd_sel_q;
        lines_d    = lines_q;
        if (release_i && full_q[rd_sel_q]) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        // A restart clears first so the restarting beat itself can count as line 1.
        if (clear_lines_i) begin
            lines_d[fill_sel_q] = '0;
        end
        if (inc_line_i && (lines_d[fill_sel_q] < LINES_MAX)) begin
            lines_d[fill_sel_q] = lines_d[fill_sel_q] + LINE_ONE;
        end
        if (mark_full_i) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = ~fill_sel_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q     <= 2'b00;
            fill_sel_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            lines_q[0] <= '0;
            lines_q[1] <= '0;
        end else begin
            full_q     <= full_d;
            fill_sel_q <= fill_sel_d;
            rd_sel_q   <= rd_sel_d;
            lines_q    <= lines_d;
        end
    end

    assign fill_sel_o   = fill_sel_q;
    assign rd_sel_o     = rd_sel_q;
    assign fill_full_o  = full_q[fill_sel_q];
    assign half_ready_o = full_q[rd_sel_q];
    assign half_lines_o = lines_q[rd_sel_q];

endmodule

// File: rtl/sm_fv_bank_loader.sv
// Loads the big-bank iteration stream into a ping-pong small-FV SRAM and serves reads.
// Optional macro SMFV_ERRCNT_EN adds err_cnt, a saturating count of dropped beats.
module sm_fv_bank_loader
    import sm_fv_pkg::*;
#(
    parameter int FV_BW  = FV_BW_C,
    parameter int ADDR_W = ADDR_W_C,
    parameter int DEPTH  = DEPTH_C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_sos,
    input  logic              in_eos,
    input  logic [FV_BW-1:0]  in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W:0]   sram_addr,
    output logic [FV_BW-1:0]  sram_d,
    input  logic [FV_BW-1:0]  sram_q,
    sm_fv_bank_loader_if.slave rd_bus,
    output logic              loaded_pulse,
    output logic              err_overflow,
    output logic              err_range
`ifdef SMFV_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);
    localparam logic [ADDR_W:0] LINES_MAX = (ADDR_W+1)'(DEPTH);

    state_e          state_q, state_d;
    logic            fill_sel, rd_sel, fill_full, half_ready;
    logic [ADDR_W:0] half_lines;
    logic            run, take, drop_sos, in_rng, wr, rd_acc, mark_full;
    logic            loaded_q, rvld_q, ovf_q, rng_q;

    // Combinational paths are held off while reset is asserted.
    assign run = reset;

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        drop_sos = 1'b0;
        if (run) begin
            if (in_sos) begin
                take     = !fill_full;
                drop_sos = fill_full;
            end else begin
                take     = (state_q == STREAM);
            end
        end
        if (drop_sos) begin
            state_d = in_eos ? IDLE : DROP;
        end else if (take) begin
            state_d = in_eos ? IDLE : STREAM;
        end else if (run && (state_q == DROP) && in_eos) begin
            state_d = IDLE;
        end
    end

    assign in_rng    = {1'b0, in_addr} < LINES_MAX;
    assign wr        = take && in_rng;
    assign mark_full = take && in_eos;

    // The stream owns the single SRAM port whenever it writes.
    assign rd_bus.rd_ready = half_ready && !wr;
    assign rd_acc          = rd_bus.rd_req && rd_bus.rd_ready;

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_d    = '0;
        if (wr) begin
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            sram_addr = {fill_sel, in_addr};
            sram_d    = in_data;
        end else if (rd_acc) begin
            sram_cen  = 1'b0;
            sram_addr = {rd_sel, rd_bus.rd_addr};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            loaded_q <= 1'b0;
            rvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rng_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= mark_full;
            rvld_q   <= rd_acc;
            if (drop_sos) ovf_q <= 1'b1;
            if (take && !in_rng) rng_q <= 1'b1;
        end
    end

    sm_fv_half_status #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_status (
        .clk           (clk),
        .reset         (reset),
        .clear_lines_i (take && in_sos),
        .inc_line_i    (wr),
        .mark_full_i   (mark_full),
        .release_i     (rd_bus.release_half),
        .fill_sel_o    (fill_sel),
        .rd_sel_o      (rd_sel),
        .fill_full_o   (fill_full),
        .half_ready_o  (half_ready),
        .half_lines_o  (half_lines)
    );

`ifdef SMFV_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       drop_beat;

    // Every cycle spent in DROP is one discarded beat of the rejected stream.
    assign drop_beat = drop_sos || (take && !in_rng) ||
                       (run && (state_q == DROP) && !in_sos);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (drop_beat && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign rd_bus.rd_valid   = rvld_q;
    assign rd_bus.rd_data    = rvld_q ? sram_q : '0;
    assign rd_bus.half_ready = half_ready;
    assign rd_bus.half_lines = half_lines;
    assign loaded_pulse      = loaded_q;
    assign err_overflow      = ovf_q;
    assign err_range         = rng_q;

endmodule

// File: tb/tb_sm_fv_bank_loader.sv
// Bench for sm_fv_bank_loader: directed table, hand sequences and random traffic
// checked against a transaction-level model of the two halves and the SRAM contents.
module tb_sm_fv_bank_loader;
    import sm_fv_pkg::*;

    localparam int FV_BW  = 64;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_sos, in_eos;
    logic [63:0] in_data;
    logic [6:0]  in_addr;
    logic        sram_cen, sram_wen;
    logic [7:0]  sram_addr;
    logic [63:0] sram_d, sram_q;
    logic        loaded_pulse, err_overflow, err_range;
`ifdef SMFV_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    sm_fv_bank_loader_if #(.FV_BW(FV_BW), .ADDR_W(ADDR_W)) bus ();

    sm_fv_bank_loader #(.FV_BW(FV_BW), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_sos       (in_sos),
        .in_eos       (in_eos),
        .in_data      (in_data),
        .in_addr      (in_addr),
        .sram_cen     (sram_cen),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_d       (sram_d),
        .sram_q       (sram_q),
        .rd_bus       (bus),
        .loaded_pulse (loaded_pulse),
        .err_overflow (err_overflow),
        .err_range    (err_range)
`ifdef SMFV_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    // Single-port SRAM with one-cycle read latency.
    logic [63:0] tb_mem [256];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) tb_mem[sram_addr] <= sram_d;
            else           sram_q <= tb_mem[sram_addr];
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what each half holds and what the consumer should see.
    bit          m_full [2];
    int          m_lines [2];
    bit          m_fill, m_rd, m_strm, m_drop, m_ovf, m_rng, m_ld, m_vld, m_rknown;
    logic [63:0] m_rdat;
    logic [63:0] m_mem [256];
    bit          m_known [256];
    int          m_cnt;

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0; m_lines[0] = 0; m_lines[1] = 0;
        m_fill = 0; m_rd = 0; m_strm = 0; m_drop = 0; m_ovf = 0; m_rng = 0;
        m_ld = 0; m_vld = 0; m_rknown = 0; m_rdat = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit ff, take, ovf, ok, wr, rdy, acc, rel;
        int idx;
        ff   = m_full[m_fill];
        take = in_sos ? !ff : m_strm;
        ovf  = in_sos && ff;
        ok   = (int'(in_addr) < DEPTH);
        wr   = take && ok;
        rdy  = m_full[m_rd] && !wr;
        acc  = bus.rd_req && rdy;
        chk("rd_ready", bus.rd_ready, rdy);
        chk("sram_cen", sram_cen, !(wr || acc));
        chk("sram_wen", sram_wen, !wr);
        if (wr) begin
            chk("wr_addr", sram_addr, {m_fill, in_addr});
            chk("wr_data", sram_d, in_data);
        end else if (acc) begin
            chk("rd_sram_addr", sram_addr, {m_rd, bus.rd_addr});
        end
        chk("half_ready", bus.half_ready, m_full[m_rd]);
        chk("half_lines", bus.half_lines, 64'(m_lines[m_rd]));
        chk("loaded_pulse", loaded_pulse, m_ld);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_range", err_range, m_rng);
        chk("rd_valid", bus.rd_valid, m_vld);
        if (!m_vld) chk("rd_data_idle", bus.rd_data, 64'd0);
        else if (m_rknown) chk("rd_data", bus.rd_data, m_rdat);
`ifdef SMFV_ERRCNT_EN
        chk("err_cnt", err_cnt, 64'(m_cnt));
`endif
        // advance
        m_vld = acc;
        if (acc) begin
            idx = {m_rd, bus.rd_addr};
            m_rdat = m_mem[idx];
            m_rknown = m_known[idx];
        end
        if (wr) begin
            idx = {m_fill, in_addr};
            m_mem[idx] = in_data;
            m_known[idx] = 1;
        end
        if (take) begin
            if (in_sos) m_lines[m_fill] = 0;
            if (ok && m_lines[m_fill] < DEPTH) m_lines[m_fill]++;
        end
        if (ovf || (m_drop && !in_sos) || (take && !ok)) begin
            if (m_cnt < 255) m_cnt++;
        end
        if (ovf) m_ovf = 1;
        if (take && !ok) m_rng = 1;
        if (ovf) begin
            m_strm = 0; m_drop = !in_eos;
        end else if (take) begin
            m_strm = !in_eos; m_drop = 0;
        end else if (m_drop && in_eos) begin
            m_drop = 0;
        end
        m_ld = take && in_eos;
        rel = bus.release_half && m_full[m_rd];
        if (take && in_eos) begin
            m_full[m_fill] = 1;
            m_fill = !m_fill;
        end
        if (rel) begin
            m_full[m_rd] = 0;
            m_rd = !m_rd;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sos, input bit eos, input logic [6:0] a, input logic [63:0] d);
        in_sos = sos; in_eos = eos; in_addr = a; in_data = d;
    endtask

    task automatic idle_in();
        drive(0, 0, 7'd0, 64'd0);
        bus.rd_req = 0; bus.rd_addr = '0; bus.release_half = 0;
    endtask

    task automatic check_reset_outs();
        chk("rst_cen", sram_cen, 1); chk("rst_wen", sram_wen, 1);
        chk("rst_addr", sram_addr, 0); chk("rst_d", sram_d, 0);
        chk("rst_rd_ready", bus.rd_ready, 0); chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0); chk("rst_half_ready", bus.half_ready, 0);
        chk("rst_half_lines", bus.half_lines, 0); chk("rst_loaded", loaded_pulse, 0);
        chk("rst_ovf", err_overflow, 0); chk("rst_rng", err_range, 0);
`ifdef SMFV_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outs();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Stream n beats into the current fill half at lines base..base+n-1.
    task automatic stream(input int n, input int base, output logic [63:0] dat [128]);
        for (int i = 0; i < n; i++) begin
            dat[i] = {$urandom, $urandom};
            drive(i == 0, i == n - 1, 7'(base + i), dat[i]);
            step();
        end
        idle_in();
    endtask

    typedef struct {
        stream_pkt_t pkt;
        bit          rq;
        logic [6:0]  ra;
        bit          rel;
        bit          e_cen, e_wen, e_rdy, e_hr;
        logic [7:0]  e_hl;
        bit          e_ld, e_vld;
    } vec_t;

    function automatic vec_t mk(bit sos, bit eos, logic [6:0] a, logic [63:0] d,
                                bit rq, logic [6:0] ra, bit rel,
                                bit cen, bit wen, bit rdy, bit hr, logic [7:0] hl,
                                bit ld, bit vld);
        vec_t v;
        v.pkt.sos = sos; v.pkt.eos = eos; v.pkt.a = a; v.pkt.fv_data = d;
        v.rq = rq; v.ra = ra; v.rel = rel;
        v.e_cen = cen; v.e_wen = wen; v.e_rdy = rdy; v.e_hr = hr;
        v.e_hl = hl; v.e_ld = ld; v.e_vld = vld;
        return v;
    endfunction

    vec_t        tbl [9];
    logic [63:0] dat [128];
    logic [63:0] dat2 [128];
    logic        rs, re;
    int          left;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        idle_in();
        reset = 1'b0;

        //            sos eos a  data          rq ra rel cen wen rdy hr hl ld vld
        tbl[0] = mk(0, 0, 7'd0, 64'h0,          0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 7'd0, 64'h1111_0000,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 7'd1, 64'h2222_0001,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
        tbl[3] = mk(0, 1, 7'd2, 64'h3333_0002,  0, 0, 0,  0, 0, 0, 0, 2, 0, 0);
        tbl[4] = mk(0, 0, 7'd0, 64'h0,          0, 0, 0,  1, 1, 1, 1, 3, 1, 0);
        tbl[5] = mk(0, 0, 7'd0, 64'h0,          1, 1, 0,  0, 1, 1, 1, 3, 0, 0);
        tbl[6] = mk(0, 0, 7'd0, 64'h0,          0, 0, 0,  1, 1, 1, 1, 3, 0, 1);
        tbl[7] = mk(0, 0, 7'd0, 64'h0,          0, 0, 1,  1, 1, 1, 1, 3, 0, 0);
        tbl[8] = mk(0, 0, 7'd0, 64'h0,          0, 0, 0,  1, 1, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].pkt.sos, tbl[i].pkt.eos, tbl[i].pkt.a, tbl[i].pkt.fv_data);
            bus.rd_req = tbl[i].rq; bus.rd_addr = tbl[i].ra; bus.release_half = tbl[i].rel;
            @(negedge clk);
            chk($sformatf("tbl%0d_cen", i), sram_cen, tbl[i].e_cen);
            chk($sformatf("tbl%0d_wen", i), sram_wen, tbl[i].e_wen);
            chk($sformatf("tbl%0d_rdy", i), bus.rd_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_hr", i), bus.half_ready, tbl[i].e_hr);
            chk($sformatf("tbl%0d_hl", i), bus.half_lines, tbl[i].e_hl);
            chk($sformatf("tbl%0d_ld", i), loaded_pulse, tbl[i].e_ld);
            chk($sformatf("tbl%0d_vld", i), bus.rd_valid, tbl[i].e_vld);
            if (i == 6) chk("tbl6_rd_data", bus.rd_data, 64'h2222_0001);
            model_step();
            @(posedge clk);
            #1;
        end

        // 64-beat stream, then read line 5, then release.
        do_reset();
        stream(64, 0, dat);
        chk("a_loaded", loaded_pulse, 1);
        chk("a_half_ready", bus.half_ready, 1);
        chk("a_half_lines", bus.half_lines, 64);
        bus.rd_req = 1; bus.rd_addr = 7'd5;
        #1;
        chk("a_rd_ready", bus.rd_ready, 1);
        step();
        bus.rd_req = 0;
        chk("a_loaded_once", loaded_pulse, 0);
        chk("a_rd_valid", bus.rd_valid, 1);
        chk("a_rd_data5", bus.rd_data, dat[5]);
        bus.release_half = 1;
        step();
        bus.release_half = 0;
        chk("a_released", bus.half_ready, 0);
        chk("a_rd_lines", bus.half_lines, 0);
        step();

        // Read held while a 4-beat stream fills half 1.
        do_reset();
        stream(4, 0, dat);
        bus.rd_req = 1; bus.rd_addr = 7'd2;
        for (int i = 0; i < 4; i++) begin
            dat2[i] = {$urandom, $urandom};
            drive(i == 0, i == 3, 7'(10 + i), dat2[i]);
            #1;
            chk($sformatf("b_blocked%0d", i), bus.rd_ready, 0);
            step();
        end
        drive(0, 0, 7'd0, 64'd0);
        #1;
        chk("b_accept", bus.rd_ready, 1);
        step();
        bus.rd_req = 0;
        chk("b_rd_valid", bus.rd_valid, 1);
        chk("b_rd_data", bus.rd_data, dat[2]);
        bus.release_half = 1;
        step();
        bus.release_half = 0;
        chk("b_half1_ready", bus.half_ready, 1);
        chk("b_half1_lines", bus.half_lines, 4);
        bus.rd_req = 1; bus.rd_addr = 7'd13;
        step();
        bus.rd_req = 0;
        chk("b_half1_data", bus.rd_data, dat2[3]);
        step();

        // Both halves full: a third stream is dropped.
        do_reset();
        stream(2, 0, dat);
        stream(2, 0, dat);
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 2, 7'(i), {$urandom, $urandom});
            #1;
            chk($sformatf("c_no_write%0d", i), sram_cen, 1);
            step();
        end
        idle_in();
        chk("c_overflow", err_overflow, 1);
        chk("c_half_ready", bus.half_ready, 1);
`ifdef SMFV_ERRCNT_EN
        chk("c_err_cnt", err_cnt, 3);
`endif
        bus.release_half = 1;
        step();
        bus.release_half = 0;
        chk("c_other_full", bus.half_ready, 1);
        chk("c_other_lines", bus.half_lines, 2);

        // Out-of-range beat in the middle of a stream.
        do_reset();
        drive(1, 0, 7'd0, 64'hA0); step();
        drive(0, 0, 7'(DEPTH), 64'hA1);
        #1;
        chk("d_no_write", sram_cen, 1);
        step();
        drive(0, 1, 7'd1, 64'hA2); step();
        idle_in();
        chk("d_err_range", err_range, 1);
        chk("d_lines", bus.half_lines, 2);
        chk("d_no_ovf", err_overflow, 0);
`ifdef SMFV_ERRCNT_EN
        chk("d_err_cnt", err_cnt, 1);
`endif
        step();

        // Line count saturates at DEPTH.
        do_reset();
        for (int i = 0; i < DEPTH + 10; i++) begin
            drive(i == 0, i == DEPTH + 9, 7'(i % DEPTH), {$urandom, $urandom});
            step();
        end
        idle_in();
        chk("e_saturate", bus.half_lines, DEPTH);
        step();

        // Reset asserted in the middle of beat 10.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 0, 7'(i), {$urandom, $urandom});
            step();
        end
        drive(0, 0, 7'd10, 64'hBEEF);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outs();
        model_reset();
        idle_in();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 7'd0, 64'hC0);
        #1;
        chk("f_restart_addr", sram_addr, 0);
        chk("f_restart_wen", sram_wen, 0);
        step();
        drive(0, 1, 7'd1, 64'hC1); step();
        idle_in();
        chk("f_half_ready", bus.half_ready, 1);
        chk("f_half_lines", bus.half_lines, 2);
        step();

        // Random traffic against the model.
        do_reset();
        left = 0;
        for (int c = 0; c < 3000; c++) begin
            rs = 0; re = 0;
            if (left == 0) begin
                if ($urandom_range(3) == 0) begin rs = 1; left = $urandom_range(24, 1); end
                else if ($urandom_range(19) == 0) re = 1;
            end else if ($urandom_range(29) == 0) begin
                rs = 1; left = $urandom_range(24, 1);
            end
            if (left > 0) begin re = (left == 1); left--; end
            drive(rs, re,
                  ($urandom_range(9) == 0) ? 7'(DEPTH + $urandom_range(27)) : 7'($urandom_range(DEPTH - 1)),
                  {$urandom, $urandom});
            bus.rd_req = 1'($urandom_range(1));
            bus.rd_addr = 7'($urandom_range(DEPTH - 1));
            bus.release_half = ($urandom_range(11) == 0);
            step();
        end
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
